// File: rtl/event_change_monitor.sv
// Change monitor for a single-bit signal: timestamps each change into a small log FIFO
// and counts rises/falls. Optional $display tracing under EVENT_CHANGE_MONITOR_DISPLAY_EN.
module event_change_monitor #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i,
  input  logic            arm,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [TS_W-1:0] rd_ts,
  output logic            rd_level,
  output logic [7:0]      rise_cnt,
  output logic [7:0]      fall_cnt,
  output logic            overflow,
  output logic            capturing
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, FROZEN} state_t;

  state_t          state;
  logic [TS_W-1:0] ts;
  logic            prev;
  logic [TS_W:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  logic            change;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [AW:0]     wr_ptr_next;
  logic [AW:0]     rd_ptr_next;
  logic [AW-1:0]   head_idx;
  logic [TS_W:0]   head_data;

  always_comb begin
    change      = i ^ prev;
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    pop         = !empty && rd_ready;
    push        = (state == CAPTURE) && change && (!full || pop);
    drop        = (state == CAPTURE) && change && full && !pop;
    wr_ptr_next = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};
    head_idx    = rd_ptr_next[AW-1:0];
    // A freshly pushed entry can become the head in the same edge; bypass the array for it.
    if (push && (head_idx == wr_ptr[AW-1:0]))
      head_data = {ts, i};
    else
      head_data = mem[head_idx];
  end

  assign rd_valid  = !empty;
  assign capturing = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {ts, i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ts       <= '0;
      prev     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_ts    <= '0;
      rd_level <= 1'b0;
      rise_cnt <= 8'd0;
      fall_cnt <= 8'd0;
      overflow <= 1'b0;
    end else begin
      ts     <= ts + 1'b1;
      prev   <= i;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (rd_ptr_next != wr_ptr_next)
        {rd_ts, rd_level} <= head_data;

      case (state)
        IDLE: begin
          if (arm)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (drop) begin
            overflow <= 1'b1;
            state    <= FROZEN;
          end
        end
        FROZEN: begin
          if (arm) begin
            overflow <= 1'b0;
            state    <= CAPTURE;
          end
        end
        default: state <= IDLE;
      endcase

      if ((state == FROZEN) && arm) begin
        rise_cnt <= 8'd0;
        fall_cnt <= 8'd0;
      end else if (push) begin
        if (i && (rise_cnt != 8'hFF))
          rise_cnt <= rise_cnt + 8'd1;
        if (!i && (fall_cnt != 8'hFF))
          fall_cnt <= fall_cnt + 8'd1;
      end
    end
  end

`ifdef EVENT_CHANGE_MONITOR_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst && push)
      $display("event_change_monitor: push ts=%0d level=%0b", ts, i);
    if (!rst && drop)
      $display("event_change_monitor: overflow, change at ts=%0d dropped", ts);
  end
`endif

endmodule

// File: tb/tb_event_change_monitor.sv
// Directed bench for event_change_monitor (DEPTH=4, TS_W=8).
module tb_event_change_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i = 1'b0;
  logic       arm = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_ts;
  logic       rd_level;
  logic [7:0] rise_cnt;
  logic [7:0] fall_cnt;
  logic       overflow;
  logic       capturing;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tb_ts = 8'd0;

  event_change_monitor #(.DEPTH(4), .TS_W(8)) dut (
    .clk(clk), .rst(rst), .i(i), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_level(rd_level),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .overflow(overflow),
    .capturing(capturing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge; tb_ts mirrors the free-running timestamp value held after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) tb_ts = 8'd0;
    else     tb_ts = tb_ts + 8'd1;
    #1;
  endtask

  // Toggle i so that the change is sampled at the edge where ts == t.
  task automatic change_at(input logic [7:0] t);
    while (tb_ts != t) tick();
    i = ~i;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; rd_ready = 1'b0; i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_valid", {31'd0, rd_valid}, 0);
    check("rst_ts", {24'd0, rd_ts}, 0);
    check("rst_level", {31'd0, rd_level}, 0);
    check("rst_rise", {24'd0, rise_cnt}, 0);
    check("rst_fall", {24'd0, fall_cnt}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_cap", {31'd0, capturing}, 0);

    // Basic capture: rise at ts=3, fall at ts=7
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_cap", {31'd0, capturing}, 1);
    change_at(8'd3);
    check("t1_valid", {31'd0, rd_valid}, 1);
    check("t1_head", {23'd0, rd_ts, rd_level}, {23'd0, 8'd3, 1'b1});
    change_at(8'd7);
    check("t1_rise", {24'd0, rise_cnt}, 1);
    check("t1_fall", {24'd0, fall_cnt}, 1);
    check("t1_ovf", {31'd0, overflow}, 0);
    rd_ready = 1'b1; tick();
    check("t1_pop_head", {23'd0, rd_ts, rd_level}, {23'd0, 8'd7, 1'b0});
    tick(); rd_ready = 1'b0;
    check("t1_empty", {31'd0, rd_valid}, 0);
    check("t1_hold", {23'd0, rd_ts, rd_level}, {23'd0, 8'd7, 1'b0});

    // IDLE ignores changes; a change coincident with arm is not recorded
    do_reset();
    for (int k = 0; k < 5; k++) begin i = ~i; tick(); end
    check("idle_valid", {31'd0, rd_valid}, 0);
    check("idle_rise", {24'd0, rise_cnt}, 0);
    check("idle_fall", {24'd0, fall_cnt}, 0);
    check("idle_cap", {31'd0, capturing}, 0);
    i = ~i; arm = 1'b1; tick(); arm = 1'b0;
    check("arm_chg_valid", {31'd0, rd_valid}, 0);
    check("arm_chg_cap", {31'd0, capturing}, 1);
    change_at(tb_ts);
    check("post_arm_valid", {31'd0, rd_valid}, 1);
    check("post_arm_ts", {24'd0, rd_ts}, {24'd0, tb_ts - 8'd1});

    // Overflow: 5 changes into DEPTH=4 with no reads
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 5; k++) begin i = ~i; tick(); end
    check("ovf_flag", {31'd0, overflow}, 1);
    check("ovf_cap", {31'd0, capturing}, 0);
    check("ovf_sum", {24'd0, rise_cnt} + {24'd0, fall_cnt}, 4);
    check("ovf_head", {23'd0, rd_ts, rd_level}, {23'd0, 8'd1, 1'b1});
    i = ~i; tick();
    check("frozen_sum", {24'd0, rise_cnt} + {24'd0, fall_cnt}, 4);
    check("frozen_ovf", {31'd0, overflow}, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    check("rearm_ovf", {31'd0, overflow}, 0);
    check("rearm_rise", {24'd0, rise_cnt}, 0);
    check("rearm_fall", {24'd0, fall_cnt}, 0);
    check("rearm_cap", {31'd0, capturing}, 1);
    check("rearm_kept", {23'd0, rd_ts, rd_level}, {23'd0, 8'd1, 1'b1});

    // Full FIFO: change plus pop in the same cycle (ts=8, i 0->1)
    i = 1'b1; rd_ready = 1'b1; tick();
    check("fullpp_ovf", {31'd0, overflow}, 0);
    check("fullpp_cap", {31'd0, capturing}, 1);
    check("fullpp_head", {23'd0, rd_ts, rd_level}, {23'd0, 8'd2, 1'b0});
    check("fullpp_rise", {24'd0, rise_cnt}, 1);
    tick(); tick(); tick();
    check("fullpp_last", {23'd0, rd_ts, rd_level}, {23'd0, 8'd8, 1'b1});
    tick(); rd_ready = 1'b0;
    check("fullpp_empty", {31'd0, rd_valid}, 0);

    // Timestamp wrap: changes at ts=255 and ts=1
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    change_at(8'd255);
    check("wrap_head0", {23'd0, rd_ts, rd_level}, {23'd0, 8'd255, 1'b1});
    change_at(8'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("wrap_head1", {23'd0, rd_ts, rd_level}, {23'd0, 8'd1, 1'b0});
    check("wrap_valid", {31'd0, rd_valid}, 1);

    // Reset mid-operation with 3 entries and overflow set
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 5; k++) begin i = ~i; tick(); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("pre_rst_ovf", {31'd0, overflow}, 1);
    check("pre_rst_head", {24'd0, rd_ts}, 2);
    rst = 1'b1; arm = 1'b1; rd_ready = 1'b1; tick();
    rst = 1'b0; arm = 1'b0; rd_ready = 1'b0;
    check("mrst_valid", {31'd0, rd_valid}, 0);
    check("mrst_ts", {24'd0, rd_ts}, 0);
    check("mrst_level", {31'd0, rd_level}, 0);
    check("mrst_cnt", {16'd0, rise_cnt, fall_cnt}, 0);
    check("mrst_ovf", {31'd0, overflow}, 0);
    check("mrst_cap", {31'd0, capturing}, 0);
    tick();
    check("mrst_after", {30'd0, rd_valid, capturing}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/event_change_monitor.md
# event_change_monitor

Synchronous receive-side monitor for a single-bit signal whose changes the producer side reports as events. Samples `i` on every `clk` edge, detects each change, records a timestamp plus new level into a small FIFO, and counts rising and falling transitions. A valid/ready read port drains the log. The block sits in regression designs as the consumer end of change-triggered producer logic, so the producer's side effects can be checked cycle-accurately.

## Interface
- `DEPTH`, 4: log FIFO entries; power of two, 2..16.
- `TS_W`, 8: timestamp width in bits.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i` in 1: monitored signal.
- `arm` in 1: single-cycle request to start or restart capture.
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_valid` out 1: head entry available.
- `rd_ts` out TS_W: timestamp of head entry.
- `rd_level` out 1: level of `i` after the recorded change.
- `rise_cnt` out 8: rising changes recorded; saturates at 255.
- `fall_cnt` out 8: falling changes recorded; saturates at 255.
- `overflow` out 1: sticky; a change was dropped.
- `capturing` out 1: state is CAPTURE.

## Operation
- Reset values: `rd_valid`=0, `rd_ts`=0, `rd_level`=0, `rise_cnt`=0, `fall_cnt`=0, `overflow`=0, `capturing`=0. The FIFO is empty, `prev`=0, `ts`=0, and the state is IDLE.
- `ts` is a free-running TS_W counter. It increments every non-reset cycle and wraps from 2^TS_W-1 to 0 without a flag.
- `prev` samples `i` every non-reset cycle in all states.
- A change is `i != prev` at an edge. A rise is `i`=1 and a fall is `i`=0.
- FSM states:
  - IDLE: changes are ignored. `arm` moves to CAPTURE.
  - CAPTURE: every change is pushed as {`ts`, `i`} and increments the matching counter.
    - If a change arrives while the FIFO is full and no pop occurs in the same cycle, the entry is dropped, the counters are not incremented, `overflow` is set, and the state moves to FROZEN.
    - `arm` while in CAPTURE has no effect.
  - FROZEN: changes are ignored. The FIFO still drains. `arm` clears `overflow`, clears both counters, and returns to CAPTURE. The FIFO is not flushed.
- A change in the same cycle as `arm`, with the state leaving IDLE or FROZEN, is not recorded.
- Read port: `rd_valid` = FIFO not empty. `rd_ts` and `rd_level` show the head entry, and hold their last value when the FIFO is empty. A pop occurs when `rd_valid && rd_ready`.
- Simultaneous push and pop:
  - When full, the pop frees a slot and the push is accepted. No overflow.
  - When empty, there is no pop (`rd_valid`=0) and the push is accepted.
- Read and write pointers use a log2(DEPTH) bit index plus one wrap bit. Full is when the indices are equal and the wrap bits differ.
- Counters saturate at 255 and never wrap.

## Timing
- A change sampled at edge k records the `ts` value held before edge k. The entry is visible with `rd_valid`=1 and the counter is updated in the cycle after edge k.
- The first edge after `rst` deasserts compares `i` against `prev`=0 and records with `ts`=0. This applies only if the block is already in CAPTURE, which is impossible directly after reset, so this change is ignored.
- `arm` at edge k sets `capturing`=1 after edge k. A change at edge k+1 is recorded.
- Pop at edge k: the next head entry (or `rd_valid`=0) appears after edge k.
- `rst` asserted mid-operation returns everything to reset values at that edge. Pending entries are discarded and `rst` overrides `arm` and `rd_ready`.
- Throughput: one push and one pop per cycle.

## Configuration
- `EVENT_CHANGE_MONITOR_DISPLAY_EN`:
  - When defined, each accepted push executes `$display` with the timestamp and level, and each drop executes `$display` with an overflow message.
  - When undefined, no system tasks are compiled in and the logic behaviour is identical.

## Test plan
- Reset, `arm`, then toggle `i` 0→1 at ts=3 and 1→0 at ts=7 → two entries {3,1} and {7,0}, `rise_cnt`=1, `fall_cnt`=1, `overflow`=0.
- IDLE state, toggle `i` 5 times → `rd_valid` stays 0, counters stay 0, `capturing`=0.
- DEPTH=4, `rd_ready`=0, 5 changes → 4 entries kept, `overflow`=1, state FROZEN, `rise_cnt`+`fall_cnt`=4. A 6th change is ignored. `arm` clears `overflow` and counters with the 4 entries still present.
- Full FIFO, change plus `rd_ready`=1 in the same cycle → oldest entry popped, new entry accepted, `overflow`=0.
- Run 300 cycles with `ts` wrap (TS_W=8), change at ts=255 and at ts=1 after wrap → entries {255,x} and {1,x}, in order.
- `rst` asserted with 3 entries queued and `overflow`=1 → all outputs at reset values the next cycle, `rd_valid`=0.
